pad_output_sampler: RTL and testbench

- Analog-to-digital end of the pad path: samples a signed node voltage on every eclk and drives a clean digital pin level.
- Rejects short excursions with a Schmitt-trigger band plus a consecutive-sample glitch filter.
- Emits one-cycle rise/fall strobes for the digital testbench side.
- Sits between the switch-level node network and the external pin models; it replaces the purely combinational sign-bit output.

---
 rtl/pad_output_sampler_pkg.sv | 19 +
 rtl/pad_output_sampler_if.sv | 21 ++
 rtl/pad_sat_counter.sv | 30 +++
 rtl/pad_output_sampler.sv | 119 +++++++++++
 tb/tb_pad_output_sampler.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pad_output_sampler_pkg.sv
// Shared types and defaults for the pad output sampler: FSM state encoding,
// default thresholds and the signed rail values of a default-width node.
package pad_output_sampler_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  localparam int W_DEF       = 16;
  localparam int VTH_HI_DEF  = 4096;
  localparam int VTH_LO_DEF  = -4096;
  localparam int FILT_DEF    = 4;
  localparam int V_RAIL_HI   = 32767;
  localparam int V_RAIL_LO   = -32768;

endpackage

// File: rtl/pad_output_sampler_if.sv
// Node-to-pin bus: sampled node voltage and enable in, filtered pin level and
// edge strobes out. PAD_SAMPLER_GLITCH_CNT_EN adds the glitch_cnt signal.
interface pad_output_sampler_if #(
  parameter int W = 16
);
  logic                en;
  logic signed [W-1:0] v;
  logic                p;
  logic                p_rise;
  logic                p_fall;
  logic                settled;
`ifdef PAD_SAMPLER_GLITCH_CNT_EN
  logic [7:0]          glitch_cnt;

  modport master (output en, v, input p, p_rise, p_fall, settled, glitch_cnt);
  modport slave  (input en, v, output p, p_rise, p_fall, settled, glitch_cnt);
`else
  modport master (output en, v, input p, p_rise, p_fall, settled);
  modport slave  (input en, v, output p, p_rise, p_fall, settled);
`endif
endinterface

// File: rtl/pad_sat_counter.sv
// 8-bit saturating up-counter with synchronous clear (priority) and increment
// enable; sticks at 255 rather than wrapping.
module pad_sat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q, cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = 8'd0;
    else if (inc) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pad_output_sampler.sv
// Schmitt-band + consecutive-sample filter turning a signed node voltage into a
// clean pin level with registered edge strobes. Option: PAD_SAMPLER_GLITCH_CNT_EN.
module pad_output_sampler
  import pad_output_sampler_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int VTH_HI      = VTH_HI_DEF,
  parameter int VTH_LO      = VTH_LO_DEF,
  parameter int FILT_CYCLES = FILT_DEF
) (
  input  logic                 eclk,
  input  logic                 erst_n,
  pad_output_sampler_if.slave  bus
);

  localparam logic signed [W-1:0] TH_HI  = W'(VTH_HI);
  localparam logic signed [W-1:0] TH_LO  = W'(VTH_LO);
  localparam logic [8:0]          FILT_N = 9'(FILT_CYCLES);

  state_t     state_q, state_d;
  logic       p_rise_q, p_rise_d;
  logic       p_fall_q, p_fall_d;
  logic       cnt_clr, cnt_inc;
  logic [7:0] cnt;
  logic       qual_hi, qual_lo, cnt_done;

  // Full-width signed compares: the rails cannot overflow.
  assign qual_hi  = (bus.v >= TH_HI);
  assign qual_lo  = (bus.v <= TH_LO);
  assign cnt_done = (({1'b0, cnt} + 9'd1) == FILT_N);

  pad_sat_counter u_filt_cnt (
    .clk   (eclk),
    .rst_n (erst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_ff @(posedge eclk) begin
    if (!erst_n) begin
      state_q  <= S_LO;
      p_rise_q <= 1'b0;
      p_fall_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_rise_q <= p_rise_d;
      p_fall_q <= p_fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        S_LO:     if (qual_hi) state_d = (FILT_CYCLES == 1) ? S_HI : S_CHK_HI;
        S_CHK_HI: if (!qual_hi) state_d = S_LO;
                  else if (cnt_done) state_d = S_HI;
        S_HI:     if (qual_lo) state_d = (FILT_CYCLES == 1) ? S_LO : S_CHK_LO;
        S_CHK_LO: if (!qual_lo) state_d = S_HI;
                  else if (cnt_done) state_d = S_LO;
        default:  state_d = S_LO;
      endcase
    end
  end

  // Any break in a qualifying run clears the filter count; en low freezes it.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    p_rise_d = 1'b0;
    p_fall_d = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_LO: if (qual_hi) begin
          if (FILT_CYCLES == 1) p_rise_d = 1'b1;
          else                  cnt_inc  = 1'b1;
        end
        S_CHK_HI: begin
          if (!qual_hi)      cnt_clr = 1'b1;
          else if (cnt_done) begin cnt_clr = 1'b1; p_rise_d = 1'b1; end
          else               cnt_inc = 1'b1;
        end
        S_HI: if (qual_lo) begin
          if (FILT_CYCLES == 1) p_fall_d = 1'b1;
          else                  cnt_inc  = 1'b1;
        end
        S_CHK_LO: begin
          if (!qual_lo)      cnt_clr = 1'b1;
          else if (cnt_done) begin cnt_clr = 1'b1; p_fall_d = 1'b1; end
          else               cnt_inc = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  assign bus.p       = (state_q == S_HI) || (state_q == S_CHK_LO);
  assign bus.settled = (state_q == S_LO) || (state_q == S_HI);
  assign bus.p_rise  = p_rise_q;
  assign bus.p_fall  = p_fall_q;

`ifdef PAD_SAMPLER_GLITCH_CNT_EN
  logic glitch_abort;

  assign glitch_abort = bus.en &&
                        (((state_q == S_CHK_HI) && !qual_hi) ||
                         ((state_q == S_CHK_LO) && !qual_lo));

  pad_sat_counter u_glitch_cnt (
    .clk   (eclk),
    .rst_n (erst_n),
    .clr   (1'b0),
    .inc   (glitch_abort),
    .cnt   (bus.glitch_cnt)
  );
`endif

endmodule

// File: tb/tb_pad_output_sampler.sv
// Directed bench for pad_output_sampler: default-filter instance plus a
// FILT_CYCLES=1 instance driven rail to rail.
module tb_pad_output_sampler;
  import pad_output_sampler_pkg::*;

  logic eclk;
  logic erst_n;
  int   n_cmp;
  int   n_err;

  pad_output_sampler_if #(.W(16)) bus  ();
  pad_output_sampler_if #(.W(16)) bus1 ();

  pad_output_sampler #(.W(16), .VTH_HI(4096), .VTH_LO(-4096), .FILT_CYCLES(4)) dut (
    .eclk   (eclk),
    .erst_n (erst_n),
    .bus    (bus)
  );

  pad_output_sampler #(.W(16), .VTH_HI(4096), .VTH_LO(-4096), .FILT_CYCLES(1)) dut1 (
    .eclk   (eclk),
    .erst_n (erst_n),
    .bus    (bus1)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge eclk);
      #1;
    end
  endtask

  task automatic check_pins(input string tag, input logic p, input logic r,
                            input logic f, input logic s);
    check({tag, ".p"},       32'(bus.p),       32'(p));
    check({tag, ".p_rise"},  32'(bus.p_rise),  32'(r));
    check({tag, ".p_fall"},  32'(bus.p_fall),  32'(f));
    check({tag, ".settled"}, 32'(bus.settled), 32'(s));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    erst_n  = 1'b0;
    bus.en  = 1'b1;
    bus.v   = 16'sd20000;
    bus1.en = 1'b0;
    bus1.v  = 16'sd0;

    // Reset dominates en and a strongly-high v.
    tick(2);
    check_pins("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.dut1_p", 32'(bus1.p), 32'd0);
`ifdef PAD_SAMPLER_GLITCH_CNT_EN
    check("reset.glitch_cnt", 32'(bus.glitch_cnt), 32'd0);
`endif

    erst_n = 1'b1;
    tick(1);
    check_pins("rel1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    check_pins("rel3", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_pins("rel4", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);
    check_pins("rel5", 1'b1, 1'b0, 1'b0, 1'b1);

    // Full-strength fall back to S_LO.
    bus.v = -16'sd20000;
    tick(3);
    check_pins("fall3", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_pins("fall4", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    check("fall5.p_fall", 32'(bus.p_fall), 32'd0);

    // Glitch: three qualifying samples then a dead-band sample.
    bus.v = 16'sd5000;
    tick(1);
    check("glitch1.settled", 32'(bus.settled), 32'd0);
    tick(2);
    check_pins("glitch3", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.v = 16'sd0;
    tick(1);
    check_pins("glitch_end", 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PAD_SAMPLER_GLITCH_CNT_EN
    check("glitch.glitch_cnt", 32'(bus.glitch_cnt), 32'd1);
`endif

    // Dead band holds S_HI; exactly VTH_LO qualifies.
    bus.v = 16'sd20000;
    tick(4);
    check("db_rise.p", 32'(bus.p), 32'd1);
    bus.v = -16'sd4000;
    tick(10);
    check_pins("deadband", 1'b1, 1'b0, 1'b0, 1'b1);
    bus.v = -16'sd4096;
    tick(3);
    check_pins("vthlo3", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_pins("vthlo4", 1'b0, 1'b0, 1'b1, 1'b1);

    // en gating: low-enable cycles neither count nor break the run.
    bus.v = 16'sd8000;
    tick(2);
    bus.en = 1'b0;
    bus.v  = -16'sd30000;
    tick(5);
    check_pins("en_low", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    bus.v  = 16'sd8000;
    tick(1);
    check_pins("en_res1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_pins("en_res2", 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset mid-qualification restarts the filter from zero.
    bus.v = -16'sd20000;
    tick(4);
    check("mid_pre.p", 32'(bus.p), 32'd0);
    bus.v = 16'sd20000;
    tick(3);
    erst_n = 1'b0;
    tick(1);
    check_pins("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PAD_SAMPLER_GLITCH_CNT_EN
    check("mid_rst.glitch_cnt", 32'(bus.glitch_cnt), 32'd0);
`endif
    erst_n = 1'b1;
    tick(3);
    check_pins("mid_req3", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_pins("mid_req4", 1'b1, 1'b1, 1'b0, 1'b1);

    // FILT_CYCLES=1: rail-to-rail every cycle toggles p with alternating strobes.
    bus1.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus1.v = (i % 2 == 0) ? 16'(V_RAIL_HI) : 16'(V_RAIL_LO);
      tick(1);
      check($sformatf("f1_%0d.p", i),      32'(bus1.p),      (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("f1_%0d.p_rise", i), 32'(bus1.p_rise), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("f1_%0d.p_fall", i), 32'(bus1.p_fall), (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
